// File: rtl/iiitb_fifo_param.sv
// iiitb_fifo_param: parametrised synchronous FIFO with thresholds, occupancy count, sticky errors and optional FWFT read
module iiitb_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_Enable,
  input  logic                  read_Enable,
  input  logic [DATA_WIDTH-1:0] buffer_Input,
  input  logic                  clear_Errors,
  output logic [DATA_WIDTH-1:0] buffer_Output,
  output logic                  sig_Full,
  output logic                  sig_Empty,
  output logic                  sig_Almost_Full,
  output logic                  sig_Almost_Empty,
  output logic [ADDR_WIDTH:0]   fill_Count,
  output logic                  sig_Overflow,
  output logic                  sig_Underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout, w_head;
  logic                  r_ovf, r_unf, w_wr_ok, w_rd_ok;
  // wrap-bit pointers make the difference the exact occupancy, 0..DEPTH
  always_comb begin
    fill_Count       = r_wr_ptr - r_rd_ptr;
    sig_Full         = fill_Count == (ADDR_WIDTH+1)'(DEPTH);
    sig_Empty        = fill_Count == '0;
    sig_Almost_Full  = fill_Count >= (ADDR_WIDTH+1)'(AFULL_THRESH);
    sig_Almost_Empty = fill_Count <= (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    w_rd_ok          = read_Enable & !sig_Empty;
    w_wr_ok          = write_Enable & (!sig_Full | w_rd_ok);
    w_head           = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    buffer_Output    = (FWFT != 0) ? (sig_Empty ? '0 : w_head) : r_dout;
    sig_Overflow     = r_ovf;
    sig_Underflow    = r_unf;
  end
  always_ff @(posedge clock)
    if (w_wr_ok && !reset) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= buffer_Input;
  // a new error outranks a coincident clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH+1)'(1);
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH+1)'(1);
        r_dout   <= w_head;
      end
      r_ovf <= (write_Enable & !w_wr_ok) | (r_ovf & !clear_Errors);
      r_unf <= (read_Enable & !w_rd_ok) | (r_unf & !clear_Errors);
    end
  end
endmodule

// File: tb/tb_iiitb_fifo_param.sv
// tb_iiitb_fifo_param: directed bench for the FIFO in registered-read and FWFT modes
module tb_iiitb_fifo_param;
  logic       clock = 1'b0, reset = 1'b0, write_Enable = 1'b0, read_Enable = 1'b0, clear_Errors = 1'b0;
  logic [7:0] buffer_Input = '0;
  logic [7:0] out_s, out_f;
  logic       full_s, empty_s, afull_s, aempty_s, ovf_s, unf_s;
  logic       full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;
  logic [4:0] cnt_s, cnt_f;
  int tests = 0, fails = 0;

  iiitb_fifo_param #(.FWFT(0)) dut (
    .clock(clock), .reset(reset), .write_Enable(write_Enable), .read_Enable(read_Enable),
    .buffer_Input(buffer_Input), .clear_Errors(clear_Errors), .buffer_Output(out_s),
    .sig_Full(full_s), .sig_Empty(empty_s), .sig_Almost_Full(afull_s), .sig_Almost_Empty(aempty_s),
    .fill_Count(cnt_s), .sig_Overflow(ovf_s), .sig_Underflow(unf_s));

  iiitb_fifo_param #(.FWFT(1)) dut_f (
    .clock(clock), .reset(reset), .write_Enable(write_Enable), .read_Enable(read_Enable),
    .buffer_Input(buffer_Input), .clear_Errors(clear_Errors), .buffer_Output(out_f),
    .sig_Full(full_f), .sig_Empty(empty_f), .sig_Almost_Full(afull_f), .sig_Almost_Empty(aempty_f),
    .fill_Count(cnt_f), .sig_Overflow(ovf_f), .sig_Underflow(unf_f));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (cnt_s !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", cnt_s); end
    tests++; if ({empty_s, aempty_s, full_s, afull_s} !== 4'b1100) begin fails++; $display("FAIL reset_flags got %b want 1100", {empty_s, aempty_s, full_s, afull_s}); end
    tests++; if ({ovf_s, unf_s} !== 2'b00) begin fails++; $display("FAIL reset_errors got %b want 00", {ovf_s, unf_s}); end
    tests++; if (out_s !== 8'h00) begin fails++; $display("FAIL reset_out got %h want 00", out_s); end
    tests++; if (out_f !== 8'h00 || empty_f !== 1'b1) begin fails++; $display("FAIL reset_fwft got out=%h empty=%b want 00/1", out_f, empty_f); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      write_Enable = 1'b1;
      buffer_Input = 8'(i);
      tick();
      tests++; if (cnt_s !== 5'(i)) begin fails++; $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt_s, i); end
      tests++; if (afull_s !== (i >= 14)) begin fails++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull_s, i >= 14); end
      tests++; if (full_s !== (i == 16)) begin fails++; $display("FAIL fill_full[%0d] got %b want %b", i, full_s, i == 16); end
      tests++; if (aempty_s !== (i <= 2)) begin fails++; $display("FAIL fill_aempty[%0d] got %b want %b", i, aempty_s, i <= 2); end
    end
    write_Enable = 1'b0;
    tests++; if (ovf_s !== 1'b0) begin fails++; $display("FAIL fill_ovf got %b want 0", ovf_s); end
  endtask

  task automatic test_overflow;
    write_Enable = 1'b1;
    buffer_Input = 8'd99;
    tick();
    write_Enable = 1'b0;
    tests++; if (ovf_s !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", ovf_s); end
    tests++; if (cnt_s !== 5'd16) begin fails++; $display("FAIL ovf_count got %0d want 16", cnt_s); end
    for (int i = 1; i <= 16; i++) begin
      read_Enable = 1'b1;
      tick();
      tests++; if (out_s !== 8'(i)) begin fails++; $display("FAIL drain_data[%0d] got %0d want %0d", i, out_s, i); end
    end
    read_Enable = 1'b0;
    tests++; if (empty_s !== 1'b1 || cnt_s !== 5'd0) begin fails++; $display("FAIL drain_empty got empty=%b cnt=%0d want 1/0", empty_s, cnt_s); end
  endtask

  task automatic test_underflow;
    read_Enable = 1'b1;
    tick();
    read_Enable = 1'b0;
    tests++; if (unf_s !== 1'b1) begin fails++; $display("FAIL unf_flag got %b want 1", unf_s); end
    tests++; if (out_s !== 8'd16) begin fails++; $display("FAIL unf_out got %0d want 16", out_s); end
    tests++; if (cnt_s !== 5'd0) begin fails++; $display("FAIL unf_count got %0d want 0", cnt_s); end
    clear_Errors = 1'b1;
    tick();
    clear_Errors = 1'b0;
    tests++; if ({ovf_s, unf_s} !== 2'b00) begin fails++; $display("FAIL clear_errors got %b want 00", {ovf_s, unf_s}); end
    // set wins over a coincident clear
    read_Enable = 1'b1;
    clear_Errors = 1'b1;
    tick();
    read_Enable = 1'b0;
    clear_Errors = 1'b0;
    tests++; if (unf_s !== 1'b1) begin fails++; $display("FAIL set_beats_clear got %b want 1", unf_s); end
    clear_Errors = 1'b1;
    tick();
    clear_Errors = 1'b0;
  endtask

  task automatic test_empty_rw;
    write_Enable = 1'b1;
    read_Enable = 1'b1;
    buffer_Input = 8'h5A;
    tick();
    write_Enable = 1'b0;
    read_Enable = 1'b0;
    tests++; if (cnt_s !== 5'd1 || unf_s !== 1'b1) begin fails++; $display("FAIL empty_rw got cnt=%0d unf=%b want 1/1", cnt_s, unf_s); end
    read_Enable = 1'b1;
    tick();
    read_Enable = 1'b0;
    clear_Errors = 1'b1;
    tests++; if (out_s !== 8'h5A || empty_s !== 1'b1) begin fails++; $display("FAIL empty_rw_pop got out=%h empty=%b want 5a/1", out_s, empty_s); end
    tick();
    clear_Errors = 1'b0;
  endtask

  task automatic test_full_rw;
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 16; j++) begin
        write_Enable = 1'b1;
        buffer_Input = 8'(r * 7 + j + 1);
        tick();
      end
      read_Enable = 1'b1;
      buffer_Input = 8'hAA;
      tick();
      write_Enable = 1'b0;
      tests++; if (out_s !== 8'(r * 7 + 1)) begin fails++; $display("FAIL frw_head[%0d] got %h want %h", r, out_s, 8'(r * 7 + 1)); end
      tests++; if (cnt_s !== 5'd16 || ovf_s !== 1'b0) begin fails++; $display("FAIL frw_state[%0d] got cnt=%0d ovf=%b want 16/0", r, cnt_s, ovf_s); end
      for (int j = 1; j < 16; j++) begin
        tick();
        if (j == 8) begin
          tests++; if (out_s !== 8'(r * 7 + j + 1)) begin fails++; $display("FAIL frw_mid[%0d] got %h want %h", r, out_s, 8'(r * 7 + j + 1)); end
        end
      end
      tick();
      read_Enable = 1'b0;
      tests++; if (out_s !== 8'hAA || empty_s !== 1'b1) begin fails++; $display("FAIL frw_last[%0d] got out=%h empty=%b want aa/1", r, out_s, empty_s); end
    end
  endtask

  task automatic test_fwft;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_Enable = 1'b1;
    buffer_Input = 8'h55;
    tick();
    write_Enable = 1'b0;
    tests++; if (out_f !== 8'h55) begin fails++; $display("FAIL fwft_show got %h want 55", out_f); end
    tests++; if (out_s !== 8'h00) begin fails++; $display("FAIL std_noread got %h want 00", out_s); end
    tick();
    tests++; if (out_f !== 8'h55 || cnt_f !== 5'd1) begin fails++; $display("FAIL fwft_hold got out=%h cnt=%0d want 55/1", out_f, cnt_f); end
    read_Enable = 1'b1;
    tick();
    read_Enable = 1'b0;
    tests++; if (out_f !== 8'h00 || empty_f !== 1'b1) begin fails++; $display("FAIL fwft_pop got out=%h empty=%b want 00/1", out_f, empty_f); end
    tests++; if (out_s !== 8'h55) begin fails++; $display("FAIL std_pop got %h want 55", out_s); end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 5; i++) begin
      write_Enable = 1'b1;
      buffer_Input = 8'(8'h10 + i);
      tick();
    end
    tests++; if (cnt_s !== 5'd5) begin fails++; $display("FAIL mid_prefill got %0d want 5", cnt_s); end
    reset = 1'b1;
    buffer_Input = 8'h77;
    tick();
    reset = 1'b0;
    write_Enable = 1'b0;
    tests++; if (cnt_s !== 5'd0 || empty_s !== 1'b1 || aempty_s !== 1'b1) begin fails++; $display("FAIL mid_reset got cnt=%0d empty=%b aempty=%b want 0/1/1", cnt_s, empty_s, aempty_s); end
    tests++; if ({ovf_s, unf_s, full_s, afull_s} !== 4'b0000 || out_s !== 8'h00) begin fails++; $display("FAIL mid_flags got %b out=%h want 0000/00", {ovf_s, unf_s, full_s, afull_s}, out_s); end
    write_Enable = 1'b1;
    buffer_Input = 8'h3C;
    tick();
    write_Enable = 1'b0;
    tests++; if (cnt_s !== 5'd1 || out_f !== 8'h3C) begin fails++; $display("FAIL mid_write got cnt=%0d fwft=%h want 1/3c", cnt_s, out_f); end
    read_Enable = 1'b1;
    tick();
    read_Enable = 1'b0;
    tests++; if (out_s !== 8'h3C || empty_s !== 1'b1) begin fails++; $display("FAIL mid_read got out=%h empty=%b want 3c/1", out_s, empty_s); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_empty_rw();
    test_full_rw();
    test_fwft();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iiitb_fifo_param.md
Name: iiitb_fifo_param

Overview:
Parametrised synchronous FIFO. It is the next-generation successor to the team's fixed 8-bit FIFO.
- Adds configurable width and depth, almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags.
- Offers a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- ADDR_WIDTH, 4: pointer width; depth = 2**ADDR_WIDTH (default 16).
- AFULL_THRESH, 14: sig_Almost_Full asserts when count >= this value; legal range 1..depth.
- AEMPTY_THRESH, 2: sig_Almost_Empty asserts when count <= this value; legal range 0..depth-1.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clock, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- write_Enable, in, 1: write request.
- read_Enable, in, 1: read/pop request.
- buffer_Input, in, DATA_WIDTH: write data.
- clear_Errors, in, 1: clears the sticky error flags.
- buffer_Output, out, DATA_WIDTH: read data.
- sig_Full, out, 1: count == depth.
- sig_Empty, out, 1: count == 0.
- sig_Almost_Full, out, 1: count >= AFULL_THRESH.
- sig_Almost_Empty, out, 1: count <= AEMPTY_THRESH.
- fill_Count, out, ADDR_WIDTH+1: current occupancy, 0..depth.
- sig_Overflow, out, 1: sticky; a write was rejected.
- sig_Underflow, out, 1: sticky; a read was rejected.

Behaviour:
- Reset (synchronous, active-high, valid mid-operation):
  - Next edge clears read/write pointers, fill_Count, buffer_Output (to 0), sig_Overflow and sig_Underflow.
  - After reset: sig_Empty=1, sig_Almost_Empty=1, sig_Full=0, sig_Almost_Full=0.
  - Storage array is not cleared.
  - Reset has priority over all other inputs.
- Pointers:
  - ADDR_WIDTH+1 bits each; the MSB is a wrap bit.
  - Storage is indexed by the low ADDR_WIDTH bits.
  - Pointers wrap naturally from depth-1 to 0.
- Write acceptance: wr_ok = write_Enable & (!sig_Full | rd_ok).
  - A full FIFO accepts a write in the same cycle as an accepted read.
  - Accepted write stores buffer_Input at wr_ptr and increments wr_ptr.
- Read acceptance: rd_ok = read_Enable & !sig_Empty.
  - An empty FIFO never accepts a read, even with a simultaneous write; the written word becomes readable next cycle.
- fill_Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
  - All status flags derive from the registered count, so they update one cycle after the accepting edge.
- FWFT=0:
  - On rd_ok, buffer_Output registers mem[rd_ptr] at that edge (1-cycle read latency).
  - Otherwise buffer_Output holds its last value.
- FWFT=1:
  - buffer_Output continuously presents mem[rd_ptr] when !sig_Empty, and 0 when empty.
  - Data is valid before read_Enable; rd_ok pops the word.
  - A word written into an empty FIFO appears on buffer_Output one cycle after the write edge.
- Errors:
  - write_Enable & !wr_ok sets sig_Overflow; data is dropped and state is unchanged.
  - read_Enable & !rd_ok sets sig_Underflow; buffer_Output is unchanged.
  - Both flags stay set until clear_Errors or reset.
  - When clear_Errors coincides with a new error, the set wins.
- Thresholds are compared against fill_Count as unsigned (ADDR_WIDTH+1)-bit values.

Test Plan:
1. Reset, then 16 writes of 1..16 with read_Enable=0 → fill_Count counts 1..16. sig_Almost_Full rises after the 14th write; sig_Full=1 after the 16th; sig_Overflow=0.
2. Full FIFO, a 17th write of 99 → sig_Overflow=1, fill_Count stays 16. Then 16 reads (FWFT=0) → buffer_Output yields 1..16, one cycle after each read; sig_Empty=1 at the end; 99 never appears.
3. Empty FIFO, read_Enable=1 → sig_Underflow=1, buffer_Output unchanged. Then clear_Errors=1 for one cycle → sig_Underflow=0.
4. Full FIFO with simultaneous write of 0xAA and read → read returns the head, fill_Count stays 16, no overflow. After draining, 0xAA is the last word out. Repeat 20 times to exercise pointer wrap.
5. FWFT=1: write 0x55 into an empty FIFO → buffer_Output=0x55 one cycle after the write edge, with no read issued. A read then pops it: sig_Empty=1 and buffer_Output=0 on the next cycle.
6. Write 5 words, assert reset for one cycle together with write_Enable=1 → fill_Count=0, sig_Empty=1, flags clear, the simultaneous write is dropped. The next write/read pair returns the new data.
